mux4_rr_arbiter: RTL
====================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter: DW, 32, data width of each requester lane and of the output lane.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: req_i  input  4  per-requester request/valid; bit k belongs to requester k.
REQ-005 SHALL have port: last_i  input  4  per-requester final-beat flag, sampled only on an accepted beat.
REQ-006 SHALL have ports: i0, i1, i2, i3  input  DW each  requester data lanes 0..3.
REQ-007 SHALL have port: out_ready_i  input  1  downstream ready.
REQ-008 SHALL have port: sel_o  output  2  registered select code driving the shared 4:1 mux (00=i0 .. 11=i3).
REQ-009 SHALL have port: gnt_o  output  4  registered one-hot grant; all-zero when idle.
REQ-010 SHALL have port: out_valid_o  output  1  downstream valid.
REQ-011 SHALL have port: out_data_o  output  DW  selected lane, combinational from sel_o.
REQ-012 SHALL have port: busy_o  output  1  high while in GRANT.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-014 IDLE: if req_i != 0, SHALL pick the winner as the first set bit of req_i searching from (ptr+1) mod 4 upward with wrap; SHALL load sel_o=winner, gnt_o=one-hot(winner), enter GRANT next edge.
REQ-015 IDLE with req_i == 0 SHALL hold state; gnt_o=0, sel_o holds its last value.
REQ-016 Arbitration latency SHALL be exactly one cycle: request seen in IDLE at edge N, gnt_o valid after edge N.
REQ-017 GRANT: out_valid_o SHALL equal req_i[sel_o]; out_data_o SHALL equal lane sel_o; in IDLE out_valid_o SHALL be 0.
REQ-018 A beat SHALL transfer when out_valid_o && out_ready_i; requester k SHALL treat gnt_o[k] && out_ready_i as its accept.
REQ-019 On a transfer with last_i[sel_o]=1, SHALL return to IDLE, set ptr=sel_o, clear gnt_o on the same edge.
REQ-020 On a transfer with last_i[sel_o]=0, or when no transfer occurs, SHALL stay in GRANT with sel_o/gnt_o unchanged (grant locked).
REQ-021 Granted requester dropping req_i mid-burst SHALL NOT release the grant; out_valid_o SHALL go low until req_i returns.
REQ-022 last_i of non-granted requesters and req_i changes of non-granted requesters SHALL have no effect during GRANT.
REQ-023 One IDLE cycle SHALL separate consecutive grants (no back-to-back regrant on the releasing edge).
REQ-024 ptr SHALL change only on release (REQ-019); it SHALL never be updated in IDLE.
REQ-025 out_data_o SHALL be a pure function of sel_o and i0..i3 (no extra register stage).

Reset
REQ-026 rst_n low SHALL immediately force: state=IDLE, gnt_o=0, sel_o=2'b00, busy_o=0, out_valid_o=0, ptr=3 (so requester 0 has first priority).
REQ-027 Reset asserted mid-burst SHALL abort the burst with no further transfer; after release the FSM SHALL arbitrate afresh from ptr=3.
REQ-028 First arbitration SHALL occur at the first rising edge after rst_n deasserts.

Verification
REQ-029 After reset, req_i=4'b1111, out_ready_i=1, last_i=4'b1111 continuously -> grants rotate 0,1,2,3,0 with one IDLE cycle between each; sel_o 00,01,10,11,00.
REQ-030 req_i=4'b0100, i2=32'hDEADBEEF, 3-beat burst (last on beat 3), out_ready_i toggling 1,0,1,0,1 -> exactly 3 transfers of lane 2, gnt_o=4'b0100 throughout, release after third accept.
REQ-031 Requester 1 granted; drop req_i[1] for 2 cycles mid-burst while req_i[3]=1 -> out_valid_o=0 for 2 cycles, gnt_o stays 4'b0010, requester 3 not granted until requester 1's last beat.
REQ-032 ptr=1 (after requester 1 released), req_i=4'b0011 -> requester 0 wins (wrap-around search 2,3,0).
REQ-033 rst_n pulsed low during requester-2 burst -> gnt_o=0, out_valid_o=0 asynchronously; with req_i=4'b0101 after release, requester 0 wins.
REQ-034 out_ready_i=0 for 10 cycles during GRANT with last_i high -> no release, gnt_o and sel_o stable, busy_o=1.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Four-requester round-robin arbiter driving a shared 4:1 data mux.
// A grant is locked until the owner's last beat transfers, then the priority pointer moves past it.
module mux4_rr_arbiter #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    req_i,
  input  logic [3:0]    last_i,
  input  logic [DW-1:0] i0,
  input  logic [DW-1:0] i1,
  input  logic [DW-1:0] i2,
  input  logic [DW-1:0] i3,
  input  logic          out_ready_i,
  output logic [1:0]    sel_o,
  output logic [3:0]    gnt_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic          busy_o
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       found;
  logic       transfer;

  // Search starts just after the last released requester and wraps around.
  always_comb begin
    winner = ptr;
    cand   = '0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req_i[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign busy_o      = (state == GRANT);
  assign out_valid_o = (state == GRANT) && req_i[sel_o];
  assign transfer    = out_valid_o && out_ready_i;

  always_comb begin
    case (sel_o)
      2'd0:    out_data_o = i0;
      2'd1:    out_data_o = i1;
      2'd2:    out_data_o = i2;
      default: out_data_o = i3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt_o <= '0;
      sel_o <= 2'b00;
      ptr   <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (req_i != 4'b0000) begin
            sel_o <= winner;
            gnt_o <= 4'b0001 << winner;
            state <= GRANT;
          end else begin
            gnt_o <= '0;
          end
        end
        GRANT: begin
          // Only the owner's final accepted beat releases; everything else keeps the lock.
          if (transfer && last_i[sel_o]) begin
            ptr   <= sel_o;
            gnt_o <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
